// File: rtl/lcd_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_linebuf_ctrl
// Description : Ping-pong line buffer controller. Tracks per-bank ownership
//               (EMPTY/FILL/FULL/READ) between the PPU writer and the
//               display reader, drives RAM addressing, reports over/underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_linebuf_ctrl #(
    parameter int WIDTH = 160,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [1:0]    mode,
    input  logic          pix_valid,
    input  logic [14:0]   pix_data,
    output logic          wr_en,
    output logic [AW:0]   wr_addr,
    output logic [14:0]   wr_data,
    input  logic          rd_line_req,
    input  logic          rd_en,
    output logic [AW:0]   rd_addr,
    output logic          rd_line_ack,
    output logic          line_ready,
    output logic          overflow,
    output logic          underflow,
    input  logic          err_clr
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_READ  = 2'd3
    } bank_state_t;

    localparam logic [AW:0]   c_width   = (AW+1)'(WIDTH);
    localparam logic [AW-1:0] c_rd_last = AW'(WIDTH - 1);

    bank_state_t r_bank_st [0:1];
    bank_state_t w_bank_st [0:1];
    logic        r_wbank, w_wbank;
    logic        r_rbank, w_rbank;
    logic [AW:0] r_wptr, w_wptr;
    logic        r_wr_block, w_wr_block;
    logic [1:0]  r_last_mode;

    logic        w_line_start, w_line_end;
    logic        w_grant, w_gbank;
    logic        w_wr_en;
    logic [AW:0] w_wr_addr;
    logic [14:0] w_wr_data;
    logic [AW:0] w_rd_addr;
    logic        w_ack, w_ovf_set, w_unf_set;

    // mode[1] distinguishes the drawing modes (10/11) from the blanking ones
    assign w_line_start = !r_last_mode[1] &&  mode[1];
    assign w_line_end   =  r_last_mode[1] && !mode[1];

    always_comb begin
        w_bank_st[0] = r_bank_st[0];
        w_bank_st[1] = r_bank_st[1];
        w_wbank      = r_wbank;
        w_rbank      = r_rbank;
        w_wptr       = r_wptr;
        w_wr_block   = r_wr_block;
        w_wr_en      = 1'b0;
        w_wr_addr    = wr_addr;
        w_wr_data    = wr_data;
        w_rd_addr    = rd_addr;
        w_ack        = 1'b0;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        w_grant      = 1'b0;
        w_gbank      = 1'b0;

        // Reader decides on the registered states, so a bank turning FULL
        // this very cycle cannot be granted until the next one.
        if (rd_line_req) begin
            if (r_bank_st[~r_rbank] == ST_FULL) begin
                w_grant = 1'b1;
                w_gbank = ~r_rbank;
            end else if (r_bank_st[r_rbank] == ST_FULL) begin
                w_grant = 1'b1;
                w_gbank = r_rbank;
            end
            if (w_grant) begin
                if (r_bank_st[r_rbank] == ST_READ)
                    w_bank_st[r_rbank] = ST_EMPTY;
                w_bank_st[w_gbank] = ST_READ;
                w_rbank   = w_gbank;
                w_rd_addr = {w_gbank, {AW{1'b0}}};
                w_ack     = 1'b1;
            end else begin
                w_unf_set = 1'b1;
                w_rd_addr = {r_rbank, {AW{1'b0}}};
            end
        end else if (rd_en && (rd_addr[AW-1:0] < c_rd_last)) begin
            w_rd_addr = {rd_addr[AW], rd_addr[AW-1:0] + 1'b1};
        end

        if (ce && pix_valid && !r_wr_block && (r_bank_st[r_wbank] == ST_FILL)) begin
            if (r_wptr < c_width) begin
                w_wr_en   = 1'b1;
                w_wr_addr = {r_wbank, r_wptr[AW-1:0]};
                w_wr_data = pix_data;
                w_wptr    = r_wptr + 1'b1;
            end else begin
                w_ovf_set = 1'b1;
            end
        end

        if (w_line_end) begin
            if (!r_wr_block && (w_bank_st[r_wbank] == ST_FILL))
                w_bank_st[r_wbank] = ST_FULL;
        end else if (w_line_start) begin
            // Release by the reader above makes a bank claimable in the same cycle.
            if (w_bank_st[0] == ST_EMPTY) begin
                w_bank_st[0] = ST_FILL;
                w_wbank      = 1'b0;
                w_wptr       = '0;
                w_wr_block   = 1'b0;
            end else if (w_bank_st[1] == ST_EMPTY) begin
                w_bank_st[1] = ST_FILL;
                w_wbank      = 1'b1;
                w_wptr       = '0;
                w_wr_block   = 1'b0;
            end else if (w_bank_st[0] == ST_FULL) begin
                w_bank_st[0] = ST_FILL;
                w_wbank      = 1'b0;
                w_wptr       = '0;
                w_wr_block   = 1'b0;
                w_ovf_set    = 1'b1;
            end else if (w_bank_st[1] == ST_FULL) begin
                w_bank_st[1] = ST_FILL;
                w_wbank      = 1'b1;
                w_wptr       = '0;
                w_wr_block   = 1'b0;
                w_ovf_set    = 1'b1;
            end else begin
                w_wr_block = 1'b1;
                w_ovf_set  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bank_st[0] <= ST_EMPTY;
            r_bank_st[1] <= ST_EMPTY;
            r_wbank      <= 1'b0;
            r_rbank      <= 1'b1;
            r_wptr       <= '0;
            r_wr_block   <= 1'b0;
            r_last_mode  <= 2'b01;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            rd_addr      <= {1'b1, {AW{1'b0}}};
            rd_line_ack  <= 1'b0;
            line_ready   <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            r_bank_st[0] <= w_bank_st[0];
            r_bank_st[1] <= w_bank_st[1];
            r_wbank      <= w_wbank;
            r_rbank      <= w_rbank;
            r_wptr       <= w_wptr;
            r_wr_block   <= w_wr_block;
            r_last_mode  <= mode;
            wr_en        <= w_wr_en;
            wr_addr      <= w_wr_addr;
            wr_data      <= w_wr_data;
            rd_addr      <= w_rd_addr;
            rd_line_ack  <= w_ack;
            line_ready   <= (r_bank_st[0] == ST_FULL) || (r_bank_st[1] == ST_FULL);
            overflow     <= w_ovf_set | (overflow  & ~err_clr);
            underflow    <= w_unf_set | (underflow & ~err_clr);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_linebuf_ctrl
// Description : Directed and randomized checks of lcd_linebuf_ctrl against a
//               transaction-level bank ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_linebuf_ctrl;
    localparam int WIDTH = 160;
    localparam int AW    = 8;
    localparam int M_EMPTY = 0, M_FILL = 1, M_FULL = 2, M_READ = 3;

    logic        clk = 1'b0, reset_n = 1'b0, ce = 1'b0, pix_valid = 1'b0;
    logic        rd_line_req = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [1:0]  mode = 2'b01;
    logic [14:0] pix_data = '0;
    logic        wr_en, rd_line_ack, line_ready, overflow, underflow;
    logic [AW:0] wr_addr, rd_addr;
    logic [14:0] wr_data;

    int n_chk  = 0;
    int n_fail = 0;
    int m_st [2];

    lcd_linebuf_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .mode(mode),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_line_req(rd_line_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_line_ack(rd_line_ack), .line_ready(line_ready),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ce = 0; pix_valid = 0; rd_line_req = 0; rd_en = 0; err_clr = 0; mode = 2'b01;
        reset_n = 0;
        step(); step();
        reset_n = 1;
        step();
        m_st[0] = M_EMPTY;
        m_st[1] = M_EMPTY;
    endtask

    task automatic line_start();
        mode = {1'b1, 1'($urandom_range(0, 1))};
        step();
    endtask

    task automatic line_end();
        mode = {1'b0, 1'($urandom_range(0, 1))};
        step();
    endtask

    task automatic idle_gap();
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
            case ($urandom_range(0, 2))
                0:       begin ce = 0; pix_valid = 0; end
                1:       begin ce = 1; pix_valid = 0; end
                default: begin ce = 0; pix_valid = 1; end
            endcase
            step();
            chk("wr_en_idle", 32'(wr_en), 0);
        end
        ce = 0; pix_valid = 0;
    endtask

    task automatic write_px(input logic [14:0] d, input bit exp_wr, input logic [AW:0] exp_addr);
        ce = 1; pix_valid = 1; pix_data = d;
        step();
        ce = 0; pix_valid = 0;
        chk("wr_en", 32'(wr_en), 32'(exp_wr));
        if (exp_wr) begin
            chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
            chk("wr_data", 32'(wr_data), 32'(d));
        end
    endtask

    task automatic write_line(input int bank, input int n, input bit rnd);
        logic [14:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 15'($urandom) : 15'(i);
            write_px(d, i < WIDTH, 9'(bank * 256 + ((i < WIDTH) ? i : 0)));
            if (rnd) idle_gap();
        end
    endtask

    task automatic read_line(input int bank, input int n_en, input bit gaps);
        int ptr;
        rd_line_req = 1;
        step();
        rd_line_req = 0;
        chk("rd_ack", 32'(rd_line_ack), 1);
        chk("rd_addr_start", 32'(rd_addr), 32'(bank * 256));
        ptr = 0;
        for (int k = 0; k < n_en; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                rd_en = 0;
                step();
                chk("rd_addr_hold", 32'(rd_addr), 32'(bank * 256 + ptr));
            end
            rd_en = 1;
            step();
            rd_en = 0;
            if (ptr < WIDTH - 1) ptr++;
            chk("rd_addr", 32'(rd_addr), 32'(bank * 256 + ptr));
        end
    endtask

    initial begin
        int b, g, n;
        bit reclaimed;

        // reset values
        do_reset();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_rd_addr", 32'(rd_addr), 32'h100);
        chk("rst_ack", 32'(rd_line_ack), 0);
        chk("rst_line_ready", 32'(line_ready), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        // full line 0..159, then readout with saturation
        line_start();
        write_line(0, WIDTH, 0);
        line_end();
        step();
        chk("ready_after_line", 32'(line_ready), 1);
        read_line(0, WIDTH + 5, 0);
        chk("ovf_clean", 32'(overflow), 0);
        chk("unf_clean", 32'(underflow), 0);

        // long line of 165 pixels into bank 1
        line_start();
        write_line(1, WIDTH, 0);
        chk("ovf_at_160", 32'(overflow), 0);
        for (int i = 0; i < 5; i++) write_px(15'h7fff, 1'b0, '0);
        chk("ovf_long_line", 32'(overflow), 1);
        line_end();
        err_clr = 1;
        step();
        err_clr = 0;
        chk("ovf_cleared", 32'(overflow), 0);

        // two lines with no reads, third reclaims bank 0
        do_reset();
        line_start(); write_line(0, 4, 1); line_end();
        line_start(); write_line(1, 4, 1); line_end();
        step();
        chk("two_full_ready", 32'(line_ready), 1);
        chk("two_full_no_ovf", 32'(overflow), 0);
        line_start();
        chk("reclaim_ovf", 32'(overflow), 1);
        write_px(15'h1234, 1'b1, 9'h000);

        // request with no FULL bank; err_clr loses to a same-cycle set
        do_reset();
        rd_en = 1;
        repeat (3) step();
        rd_en = 0;
        chk("rd_free_run", 32'(rd_addr), 32'h103);
        rd_line_req = 1; err_clr = 1;
        step();
        rd_line_req = 0;
        chk("unf_set", 32'(underflow), 1);
        chk("unf_no_ack", 32'(rd_line_ack), 0);
        chk("unf_rd_addr", 32'(rd_addr), 32'h100);
        step();
        err_clr = 0;
        chk("unf_cleared", 32'(underflow), 0);

        // same-cycle line end (bank 1) and request (bank 0 READ)
        do_reset();
        line_start(); write_line(0, 4, 1); line_end();
        read_line(0, 2, 0);
        line_start(); write_line(1, 4, 1);
        mode = 2'b00; rd_line_req = 1;
        step();
        rd_line_req = 0;
        chk("same_cycle_ack", 32'(rd_line_ack), 0);
        chk("same_cycle_unf", 32'(underflow), 1);
        chk("same_cycle_reread", 32'(rd_addr), 32'h000);
        step();
        rd_line_req = 1;
        step();
        rd_line_req = 0;
        chk("next_req_ack", 32'(rd_line_ack), 1);
        chk("next_req_addr", 32'(rd_addr), 32'h100);

        // reset in the middle of a line
        do_reset();
        line_start();
        write_line(0, 80, 0);
        reset_n = 0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 0);
        chk("mid_rst_wr_data", 32'(wr_data), 0);
        chk("mid_rst_rd_addr", 32'(rd_addr), 32'h100);
        chk("mid_rst_ack", 32'(rd_line_ack), 0);
        chk("mid_rst_ready", 32'(line_ready), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_unf", 32'(underflow), 0);
        mode = 2'b01;
        step();
        reset_n = 1;
        repeat (3) step();
        chk("post_rst_ready", 32'(line_ready), 0);

        // randomized lines against the bank ownership model
        do_reset();
        for (int line = 0; line < 8; line++) begin
            reclaimed = 0;
            b = -1;
            for (int k = 0; k < 2; k++)
                if (b < 0 && m_st[k] == M_EMPTY) b = k;
            for (int k = 0; k < 2; k++)
                if (b < 0 && m_st[k] == M_FULL) begin b = k; reclaimed = 1; end
            m_st[b] = M_FILL;
            line_start();
            n = $urandom_range(1, WIDTH + 10);
            write_line(b, n, 1);
            line_end();
            m_st[b] = M_FULL;
            step();
            chk("rnd_ready", 32'(line_ready), 1);
            chk("rnd_ovf", 32'(overflow), 32'(reclaimed || (n > WIDTH)));
            err_clr = 1;
            step();
            err_clr = 0;
            chk("rnd_ovf_clr", 32'(overflow), 0);
            if (line == 0 || $urandom_range(0, 3) != 0) begin
                g = -1;
                for (int k = 0; k < 2; k++)
                    if (g < 0 && m_st[k] == M_FULL) g = k;
                for (int k = 0; k < 2; k++)
                    if (m_st[k] == M_READ) m_st[k] = M_EMPTY;
                m_st[g] = M_READ;
                read_line(g, $urandom_range(0, WIDTH + 10), 1);
                chk("rnd_unf", 32'(underflow), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
